// File: rtl/video_line_fetch_if.sv
// Memory video read port: word-aligned byte address out, read data returned one clock later.
interface video_line_fetch_if;
  logic [31:0] adr;
  logic [31:0] data;

  modport master (output adr, input data);
  modport slave  (input adr, output data);
endinterface

// File: rtl/video_line_fetch.sv
// Ping-pong scanline prefetcher: fills one line buffer during hblank while the other streams pixels.
// Optional VLF_SKIP_REFETCH_EN: skip a burst when the display buffer already holds the requested row.
//
// state | meaning
// IDLE  | waiting for hcount==H_ACTIVE on a line whose successor is visible
// FETCH | issuing word addresses 0..WPL-1 of the latched row
// DRAIN | capturing the word returned for the last address
// DONE  | fill buffer valid, waiting for the end-of-line swap
module video_line_fetch #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          FB_W        = 160,
  parameter int          SHIFT       = 2,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          H_TOTAL     = 800,
  parameter int          V_TOTAL     = 525,
  parameter logic [7:0]  BLANK_COLOR = 8'h00
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  video_line_fetch_if.master mem,
  output logic [7:0]         pixel,
  output logic               fetch_busy,
  output logic               underrun
);

  localparam int WPL = FB_W / 4;
  localparam int WW  = $clog2(WPL);
  localparam int RW  = 10 - SHIFT;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        state;
  logic          disp_sel;
  logic [1:0]    buf_valid;
  logic [WW-1:0] w_idx;
  logic [31:0]   line_buf [2][WPL];

  logic [9:0]    next_line;
  logic          fetch_req;
  logic [RW-1:0] row;
  logic [31:0]   row_addr;
  logic          skip;
  logic [WW-1:0] rd_word;
  logic [1:0]    rd_byte;
  logic [31:0]   rd_data;

`ifdef VLF_SKIP_REFETCH_EN
  logic [RW-1:0] buf_row [2];
`endif

  always_comb begin
    next_line = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    fetch_req = next_line < 10'(V_ACTIVE);
    row       = next_line[9:SHIFT];
    row_addr  = BASE_ADDR + ((32'(row) * 32'(WPL)) << 2);
`ifdef VLF_SKIP_REFETCH_EN
    skip      = buf_valid[disp_sel] && (buf_row[disp_sel] == row);
`else
    skip      = 1'b0;
`endif
    rd_word   = hcount[SHIFT+WW+1:SHIFT+2];
    rd_byte   = hcount[SHIFT+1:SHIFT];
    rd_data   = line_buf[disp_sel][rd_word];
  end

  // The end-of-line swap takes priority over every other transition.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      disp_sel   <= 1'b0;
      buf_valid  <= 2'b00;
      w_idx      <= '0;
      mem.adr    <= BASE_ADDR;
      fetch_busy <= 1'b0;
      underrun   <= 1'b0;
`ifdef VLF_SKIP_REFETCH_EN
      buf_row[0] <= '0;
      buf_row[1] <= '0;
`endif
    end else if (hcount == 10'(H_TOTAL - 1)) begin
      case (state)
        DONE: begin
          disp_sel <= ~disp_sel;
          state    <= IDLE;
        end
        FETCH, DRAIN: begin
          underrun   <= 1'b1;
          disp_sel   <= ~disp_sel;
          fetch_busy <= 1'b0;
          state      <= IDLE;
        end
        default: ;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (hcount == 10'(H_ACTIVE) && fetch_req && !skip) begin
            state                <= FETCH;
            buf_valid[~disp_sel] <= 1'b0;
            w_idx                <= '0;
            mem.adr              <= row_addr;
            fetch_busy           <= 1'b1;
`ifdef VLF_SKIP_REFETCH_EN
            buf_row[~disp_sel]   <= row;
`endif
          end
        end
        FETCH: begin
          if (w_idx == WW'(WPL - 1)) begin
            state <= DRAIN;
          end else begin
            w_idx   <= w_idx + WW'(1);
            mem.adr <= mem.adr + 32'd4;
          end
        end
        DRAIN: begin
          state                <= DONE;
          buf_valid[~disp_sel] <= 1'b1;
          fetch_busy           <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Read data lags the address by one clock, so each FETCH cycle stores the previous word.
  always_ff @(posedge CLK) begin
    if (state == FETCH && w_idx != '0)
      line_buf[~disp_sel][w_idx - WW'(1)] <= mem.data;
    else if (state == DRAIN)
      line_buf[~disp_sel][WW'(WPL - 1)] <= mem.data;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      pixel <= BLANK_COLOR;
    else if (hcount >= 10'(H_ACTIVE) || vcount >= 10'(V_ACTIVE) || !buf_valid[disp_sel])
      pixel <= BLANK_COLOR;
    else
      pixel <= rd_data[{rd_byte, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed line-by-line bench for video_line_fetch: pixel scoreboard, behavioural memory, burst checks.
`timescale 1ns/1ps
module tb_video_line_fetch;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          WPL  = 40;
`ifdef VLF_SKIP_REFETCH_EN
  localparam int EXP_READS_0_5 = 2 * WPL;
`else
  localparam int EXP_READS_0_5 = 6 * WPL;
`endif

  logic       CLK = 1'b0;
  logic       reset;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [7:0] pixel;
  logic       fetch_busy;
  logic       underrun;

  video_line_fetch_if mif();

  video_line_fetch dut (
    .CLK        (CLK),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .mem        (mif),
    .pixel      (pixel),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  always #20 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    logic [7:0]  r;
    logic [7:0]  k;
    idx = (a - BASE) >> 2;
    r   = 8'(idx / WPL);
    k   = 8'(idx % WPL);
    return {r, k, 8'hA5, 8'h3C};
  endfunction

  always @(posedge CLK) mif.data <= mem_word(mif.adr);

  int   checks = 0;
  int   errors = 0;
  bit   model_valid;
  int   model_row;
  bit   exp_underrun;
  logic [7:0] exp_q[$];

  int   bursts = 0;
  logic busy_d = 1'b0;
  always @(posedge CLK) begin
    busy_d <= fetch_busy;
    if (fetch_busy === 1'b1 && busy_d !== 1'b1) bursts <= bursts + 1;
  end

  function automatic logic [7:0] exp_pix(input int h, input int v);
    logic [31:0] w;
    if (h >= 640 || v >= 480 || !model_valid) return 8'h00;
    w = {8'(model_row), 8'(h >> 4), 8'hA5, 8'h3C};
    return w[8 * ((h >> 2) % 4) +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int h, input int v);
    logic [7:0] e;
    hcount = 10'(h);
    vcount = 10'(v);
    exp_q.push_back(exp_pix(h, v));
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("pixel v%0d h%0d", v, h), {24'd0, pixel}, {24'd0, e});
  endtask

  // stall presents hcount==640 late (at cycle 790) so the burst cannot finish before the swap.
  task automatic run_line(input int v, input bit stall, input int stop_h);
    int nl;
    int row;
    int busy_n;
    bit req;
    bit do_fetch;
    nl  = (v == 524) ? 0 : v + 1;
    req = nl < 480;
    row = nl >> 2;
`ifdef VLF_SKIP_REFETCH_EN
    do_fetch = req && !(model_valid && model_row == row);
`else
    do_fetch = req;
`endif
    busy_n = 0;
    for (int pos = 0; pos <= stop_h; pos++) begin
      int h;
      if (!stall || pos < 640)  h = pos;
      else if (pos < 790)       h = pos + 1;
      else if (pos == 790)      h = 640;
      else                      h = pos;
      step(h, v);
      if (!stall && do_fetch && h >= 640 && h <= 679)
        chk($sformatf("adr v%0d h%0d", v, h), mif.adr, BASE + 32'(160 * row) + 32'(4 * (h - 640)));
      if (!stall && h >= 640 && h <= 700 && fetch_busy === 1'b1) busy_n++;
      if (stall && pos == 795) chk("stall busy", {31'd0, fetch_busy}, 32'd1);
    end
    if (stop_h == 799) begin
      if (stall) begin
        exp_underrun = 1'b1;
        chk("abort busy", {31'd0, fetch_busy}, 32'd0);
        model_valid = 1'b0;
      end else begin
        chk($sformatf("busy cycles v%0d", v), 32'(busy_n), do_fetch ? 32'd41 : 32'd0);
        if (req) begin
          model_valid = 1'b1;
          model_row   = row;
        end
      end
      chk($sformatf("underrun v%0d", v), {31'd0, underrun}, {31'd0, exp_underrun});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    reset        = 1'b1;
    hcount       = 10'd0;
    vcount       = 10'd0;
    model_valid  = 1'b0;
    model_row    = 0;
    exp_underrun = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset adr", mif.adr, BASE);
    chk("reset pixel", {24'd0, pixel}, 32'd0);
    chk("reset busy", {31'd0, fetch_busy}, 32'd0);
    chk("reset underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;

    b0 = bursts;
    for (int v = 0; v < 6; v++) run_line(v, 1'b0, 799);
    chk("reads lines 0-5", 32'((bursts - b0) * WPL), 32'(EXP_READS_0_5));

    run_line(479, 1'b0, 799);
    run_line(480, 1'b0, 799);
    run_line(524, 1'b0, 799);
    for (int v = 0; v < 7; v++) run_line(v, 1'b0, 799);
    run_line(7, 1'b1, 799);
    for (int v = 8; v < 11; v++) run_line(v, 1'b0, 799);

    run_line(11, 1'b0, 660);
    reset = 1'b1;
    #1;
    chk("midburst adr", mif.adr, BASE);
    chk("midburst busy", {31'd0, fetch_busy}, 32'd0);
    chk("midburst pixel", {24'd0, pixel}, 32'd0);
    chk("midburst underrun", {31'd0, underrun}, 32'd0);
    model_valid  = 1'b0;
    exp_underrun = 1'b0;
    hcount       = 10'd0;
    vcount       = 10'd0;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    for (int v = 0; v < 3; v++) run_line(v, 1'b0, 799);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
